// File: rtl/counter8_seq.sv
// Interval-timer sequencer that owns the control pins of one counter8.
// Ports: clk, clr (async active-low reset); start/stop/periodic/start_val/
//   term_val commands; cnt_q counter feedback; cnt_clr/cnt_l/cnt_ss/cnt_d
//   counter controls; busy, done, err status pulses; periods tally.
module counter8_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    input  logic [W-1:0] start_val,
    input  logic [W-1:0] term_val,
    input  logic [W-1:0] cnt_q,
    output logic         cnt_clr,
    output logic         cnt_l,
    output logic         cnt_ss,
    output logic [W-1:0] cnt_d,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   periods
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t       state;
    logic [W-1:0] sv_r;
    logic [W-1:0] tv_r;
    logic         per_r;
    logic         at_term;
    logic         cmd_ok;

    assign at_term = (cnt_q == tv_r);
    assign cmd_ok  = (start_val <= term_val);

    // Counter controls come straight from state so that reset forces
    // a clear onto counter8 without waiting for a clock edge.
    assign cnt_clr = (state == CLEAR);
    assign cnt_l   = (state == LOAD);
    assign cnt_d   = sv_r;
    assign cnt_ss  = (state == RUN) && !at_term;
    assign busy    = (state == LOAD) || (state == RUN);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= CLEAR;
            sv_r    <= '0;
            tv_r    <= '0;
            per_r   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            periods <= 8'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                CLEAR: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (start) begin
                        if (cmd_ok) begin
                            sv_r    <= start_val;
                            tv_r    <= term_val;
                            per_r   <= periodic;
                            periods <= 8'd0;
                            state   <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state <= CLEAR;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // stop outranks a terminal seen in the same cycle
                    if (stop) begin
                        state <= CLEAR;
                    end else if (at_term) begin
                        done <= 1'b1;
                        if (per_r) begin
                            periods <= periods + 8'd1;
                            state   <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter8_seq.sv
// Scoreboard bench for counter8_seq with a behavioural counter8 attached.
// Expected done/err pulses are queued at command time and popped by a monitor.
module tb_counter8_seq;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic [7:0] start_val = 8'd0;
    logic [7:0] term_val = 8'd0;
    logic [7:0] cnt_q = 8'd0;
    logic       cnt_clr;
    logic       cnt_l;
    logic       cnt_ss;
    logic [7:0] cnt_d;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] periods;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int mper = 0;

    typedef struct {
        bit kind;
        int cyc;
        int per;
    } ev_t;
    ev_t exq[$];

    counter8_seq #(.W(8)) dut (
        .clk(clk),
        .clr(clr),
        .start(start),
        .stop(stop),
        .periodic(periodic),
        .start_val(start_val),
        .term_val(term_val),
        .cnt_q(cnt_q),
        .cnt_clr(cnt_clr),
        .cnt_l(cnt_l),
        .cnt_ss(cnt_ss),
        .cnt_d(cnt_d),
        .busy(busy),
        .done(done),
        .err(err),
        .periods(periods)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // counter8: synchronous clr, then load, then count
    always @(posedge clk) begin
        if (cnt_clr) cnt_q <= 8'd0;
        else if (cnt_l) cnt_q <= cnt_d;
        else if (cnt_ss) cnt_q <= cnt_q + 8'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (done || err) begin
            if (exq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none (cycle %0d)",
                         done, err, cyc);
            end else begin
                ev_t e;
                e = exq.pop_front();
                chk("pulse_kind", int'(err), int'(e.kind));
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_periods", int'(periods), e.per);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // s = offset of the edge that samples stop (0 = no stop)
    task automatic run_cmd(input int sv, input int tv, input bit per, input int s);
        int k, L, n, endj, ec;
        bit eff, eb;
        L = tv - sv + 2;
        start = 1'b1;
        start_val = 8'(sv);
        term_val = 8'(tv);
        periodic = per;
        tick();
        start = 1'b0;
        k = cyc;
        eff = (s > 0) && (per || s <= L);
        if (per) n = (s - 1) / L;
        else n = (s == 0 || L < s) ? 1 : 0;
        for (int i = 1; i <= n; i++)
            exq.push_back('{1'b0, k + i * L, per ? i : 0});
        endj = ((s > L) ? s : L) + 2;
        for (int j = 0; j <= endj; j++) begin
            eb = (!eff || j < s) && (per || j < L);
            chk("busy", int'(busy), int'(eb));
            chk("cnt_clr", int'(cnt_clr), int'(eff && j == s));
            if (j >= 1) begin
                if (eff && j > s) ec = 0;
                else if (!per && j >= L) ec = tv;
                else ec = sv + (((j - 1) % L < L - 2) ? (j - 1) % L : L - 2);
                chk("cnt_q", int'(cnt_q), ec);
            end
            stop = (j == s - 1);
            start = eb && ($urandom_range(0, 3) == 0);
            start_val = 8'($urandom);
            term_val = 8'($urandom);
            periodic = 1'($urandom);
            tick();
        end
        stop = 1'b0;
        start = 1'b0;
        mper = per ? n : 0;
        chk("periods_end", int'(periods), mper);
    endtask

    task automatic run_err(input int sv, input int tv);
        int prev;
        prev = int'(cnt_q);
        start = 1'b1;
        start_val = 8'(sv);
        term_val = 8'(tv);
        periodic = 1'($urandom);
        tick();
        start = 1'b0;
        exq.push_back('{1'b1, cyc, mper});
        for (int j = 0; j < 3; j++) begin
            chk("err_busy", int'(busy), 0);
            chk("err_cnt_l", int'(cnt_l), 0);
            chk("err_cnt_q", int'(cnt_q), prev);
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv, tv, L, s;
        bit per;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt_clr", int'(cnt_clr), 1);
        chk("rst_cnt_ss", int'(cnt_ss), 0);
        chk("rst_cnt_l", int'(cnt_l), 0);
        chk("rst_busy", int'(busy), 0);
        clr = 1'b1;
        chk("rel_cnt_clr", int'(cnt_clr), 1);
        chk("rel_periods", int'(periods), 0);
        tick();
        chk("idle_cnt_clr", int'(cnt_clr), 0);
        chk("idle_cnt_q", int'(cnt_q), 0);
        chk("idle_busy", int'(busy), 0);

        run_cmd(8'hF0, 8'hF3, 1'b0, 0);
        run_cmd(8'hFE, 8'hFF, 1'b1, 31);
        chk("ten_periods", int'(periods), 10);
        run_err(8'h10, 8'h05);
        run_cmd(8'hF0, 8'hFF, 1'b0, 3);
        run_cmd(8'h20, 8'h24, 1'b0, 6);
        run_cmd(8'h33, 8'h33, 1'b1, 7);

        start = 1'b1;
        start_val = 8'hFE;
        term_val = 8'hFF;
        periodic = 1'b1;
        tick();
        start = 1'b0;
        exq.push_back('{1'b0, cyc + 3, 1});
        repeat (4) tick();
        chk("pre_rst_periods", int'(periods), 1);
        chk("pre_rst_busy", int'(busy), 1);
        clr = 1'b0;
        #1;
        chk("mid_rst_cnt_clr", int'(cnt_clr), 1);
        chk("mid_rst_cnt_ss", int'(cnt_ss), 0);
        chk("mid_rst_periods", int'(periods), 0);
        chk("mid_rst_busy", int'(busy), 0);
        tick();
        clr = 1'b1;
        mper = 0;
        tick();
        chk("post_rst_cnt_clr", int'(cnt_clr), 0);
        chk("post_rst_cnt_q", int'(cnt_q), 0);

        for (int i = 0; i < 40; i++) begin
            sv = $urandom_range(0, 255);
            if (sv > 0 && $urandom_range(0, 5) == 0) begin
                run_err(sv, $urandom_range(0, sv - 1));
            end else begin
                tv = sv + $urandom_range(0, (255 - sv < 12) ? 255 - sv : 12);
                L = tv - sv + 2;
                per = 1'($urandom);
                if (per) s = $urandom_range(1, 4 * L);
                else s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, L + 1);
                run_cmd(sv, tv, per, s);
            end
        end

        repeat (2) tick();
        chk("queue_empty", exq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter8_seq.md
Name: counter8_seq

Overview:
- Sequencer that owns the control pins of one counter8 instance (clr, l, s_s, d) and turns it into a programmable interval timer.
- Runs the counter from a start value to a terminal value, in one-shot or periodic mode.
- Reports completion pulses, a period tally and a rejected-command error.
- Sits between the host command logic and counter8; counter8's c output feeds back into this block.

Parameters:
- W, 8, counter data width; must match counter8.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- stop  in  1  abort request; highest command priority.
- periodic  in  1  1 = reload and rerun at terminal; 0 = one-shot. Captured with start.
- start_val  in  W  counter load value. Captured with start.
- term_val  in  W  terminal value. Captured with start.
- cnt_q  in  W  counter8 c output.
- cnt_clr  out  1  drives counter8 clr.
- cnt_l  out  1  drives counter8 l.
- cnt_ss  out  1  drives counter8 s_s.
- cnt_d  out  W  drives counter8 d.
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle pulse per completed run.
- err  out  1  one-cycle pulse when a start is rejected.
- periods  out  8  completed-period tally.

Behaviour:
- counter8 contract (fixed):
  - synchronous clr has highest priority, then l (load d), then count up by 1 when s_s=1.
  - cnt_q reflects the value after the edge.
- Registers: state, sv_r, tv_r, per_r, done, err, periods. All reset asynchronously on clr=0:
  - state=CLEAR
  - sv_r=tv_r=0, per_r=0
  - done=0, err=0, periods=0
- Outputs decoded from state:
  - cnt_clr = (state==CLEAR)
  - cnt_l = (state==LOAD)
  - cnt_d = sv_r
  - cnt_ss = (state==RUN) && (cnt_q != tv_r)
  - busy = LOAD|RUN
- During reset: cnt_clr=1, cnt_l=0, cnt_ss=0, busy=0.
- CLEAR: one cycle, then IDLE.
- IDLE:
  - start=1 and start_val<=term_val: capture sv_r, tv_r, per_r; periods<=0; go to LOAD.
  - start=1 and start_val>term_val: err<=1 for one cycle; stay in IDLE; captured registers unchanged.
  - The counter holds its last value.
- LOAD: one cycle; the counter loads sv_r at the closing edge; go to RUN.
- RUN:
  - Counts while cnt_q != tv_r.
  - When cnt_q == tv_r: cnt_ss=0 that cycle; at the next edge done<=1 for one cycle.
  - Then per_r=1: periods<=periods+1 (wraps 255->0) and go to LOAD. Otherwise go to IDLE; the counter keeps tv_r.
- stop=1 in LOAD or RUN: next state CLEAR; no done; periods unchanged. stop in IDLE or CLEAR is ignored.
- Priority in RUN: stop > terminal. stop and terminal in the same cycle -> CLEAR, done=0.
- start while busy is ignored (no err).
- Timing, with start sampled at edge E0:
  - LOAD occupies the cycle after E0.
  - RUN is entered at E1; cnt_q=sv_r after E1.
  - done is high in the cycle after E(tv-sv+2).
  - Periodic period = tv-sv+2 cycles.
- start_val==term_val: RUN sees terminal immediately; cnt_ss never asserts; done arrives 2 cycles after start (periodic: every 2 cycles).
- term_val=all-ones: the terminal is reached before wrap; the counter never overflows under this block.
- Reset mid-run: immediate CLEAR outputs; all tallies zeroed.

Test Plan:
- Reset release, no commands -> cnt_clr=1 for one cycle after clr rises, then IDLE; cnt_ss=0, busy=0, periods=0.
- One-shot, start_val=8'hF0, term_val=8'hF3 -> cnt_l for 1 cycle; cnt_q steps F0,F1,F2,F3; done high in the 5th cycle after the start edge; busy drops; cnt_q stays F3.
- Periodic, start_val=8'hFE, term_val=8'hFF, run 10 periods -> done every 3 cycles; periods=10; cnt_q never shows 8'h00.
- Error, start_val=8'h10, term_val=8'h05 -> err 1-cycle pulse; state stays IDLE; busy=0; cnt_l never asserts.
- Stop at cnt_q=8'hF1 (sv F0, tv FF) -> next cycle cnt_clr=1, then IDLE; done never pulses; cnt_q=0 afterward.
- clr driven low mid-RUN for 1 cycle, start pulse during busy, and stop coinciding with terminal:
  - clr low -> immediate cnt_ss=0, cnt_clr=1, periods=0.
  - extra start -> ignored.
  - coincident stop -> CLEAR, no done.
